fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory's word address. It registers the returned 32-bit instruction into the IF/ID output register using a valid/ready handshake. It also handles redirects from decode: jump/branch, CALL with a return-address-stack push, and RET with a pop.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_unit_ras_stack.sv | 63 ++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [1:0] REDIR_JMP  = 2'd0;
    localparam logic [1:0] REDIR_CALL = 2'd1;
    localparam logic [1:0] REDIR_RET  = 2'd2;
    localparam logic [1:0] REDIR_RSVD = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Sequential PC with wrap at the end of instruction memory.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc, input logic [31:0] words);
        logic [31:0] nxt;
        if (pc == (words - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = pc + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, IF/ID output and redirect signals of the fetch stage.
interface fetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_target;
    logic [31:0] redir_ret_addr;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redir_valid,
        input  redir_kind,
        input  redir_target,
        input  redir_ret_addr
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redir_valid,
        output redir_kind,
        output redir_target,
        output redir_ret_addr
    );

endinterface

// File: rtl/fetch_unit_ras_stack.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module ras_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] top,
    output logic        empty,
    output logic        full,
    output logic        overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic [PW-1:0] top_idx_s;

    // Top of stack sits just below the write pointer.
    always_comb begin
        top_idx_s = wr_ptr_r - PW'(1);
        top       = mem_r[top_idx_s];
        empty     = (count_r == {CW{1'b0}});
        full      = (count_r == DEPTH_C);
        overflow  = overflow_r;
    end

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
            if (full) begin
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_r <= top_idx_s;
            count_r  <= count_r - CW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, registers the fetched instruction into IF/ID and services redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_WORDS = 1024,
    parameter int          RAS_DEPTH  = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus,
    output logic   ras_overflow,
    output logic   fault
);

    localparam logic [31:0] WORDS_C = 32'(IMEM_WORDS);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic         out_valid_r;
    logic [31:0]  out_instr_r;
    logic [31:0]  out_pc_r;
    logic         fault_r;
    logic         ras_overflow_r;

    logic         load_s;
    logic         redir_s;
    logic         push_s;
    logic         pop_s;
    logic         ret_fault_s;
    logic [31:0]  redir_pc_s;
    logic [31:0]  ras_top_s;
    logic         ras_empty_s;
    logic         ras_full_s;
    logic         ras_ovf_s;

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .pop      (pop_s),
        .din      (bus.redir_ret_addr),
        .top      (ras_top_s),
        .empty    (ras_empty_s),
        .full     (ras_full_s),
        .overflow (ras_ovf_s)
    );

    // Redirect decode; only RUN reacts, and the reserved kind is not a redirect.
    always_comb begin
        load_s      = !out_valid_r || bus.out_ready;
        redir_s     = (state_r == ST_RUN) && bus.redir_valid && (bus.redir_kind != REDIR_RSVD);
        push_s      = redir_s && (bus.redir_kind == REDIR_CALL);
        pop_s       = redir_s && (bus.redir_kind == REDIR_RET) && !ras_empty_s;
        ret_fault_s = redir_s && (bus.redir_kind == REDIR_RET) && ras_empty_s;
        case (bus.redir_kind)
            REDIR_RET: redir_pc_s = ras_top_s;
            default:   redir_pc_s = bus.redir_target;
        endcase
    end

    // FSM, PC and IF/ID output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_BOOT;
            pc_r           <= RESET_PC;
            out_valid_r    <= 1'b0;
            out_instr_r    <= NOP_INSTR;
            out_pc_r       <= 32'd0;
            fault_r        <= 1'b0;
            ras_overflow_r <= 1'b0;
        end else begin
            ras_overflow_r <= ras_ovf_s || (push_s && ras_full_s);
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (redir_s) begin
                        out_valid_r <= 1'b0;
                        if (ret_fault_s) begin
                            state_r <= ST_FAULT;
                            fault_r <= 1'b1;
                        end else begin
                            pc_r <= redir_pc_s;
                        end
                    end else if (load_s) begin
                        out_instr_r <= bus.imem_instr;
                        out_pc_r    <= pc_r;
                        out_valid_r <= 1'b1;
                        pc_r        <= pc_incr(pc_r, WORDS_C);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FAULT: begin
                    out_valid_r <= 1'b0;
                    fault_r     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_FAULT;
                    out_valid_r <= 1'b0;
                    fault_r     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_pc    = out_pc_r;
    assign fault         = fault_r;
    assign ras_overflow  = ras_overflow_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns address + 100.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;
    logic ras_overflow;
    logic fault;
    int   checks;
    int   errors;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC   (32'd0),
        .IMEM_WORDS (1024),
        .RAS_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ras_overflow (ras_overflow),
        .fault        (fault)
    );

    assign bus.imem_instr = bus.imem_addr + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] kind, input logic [31:0] tgt, input logic [31:0] ret);
        bus.redir_valid    = 1'b1;
        bus.redir_kind     = kind;
        bus.redir_target   = tgt;
        bus.redir_ret_addr = ret;
    endtask

    task automatic no_redir();
        bus.redir_valid    = 1'b0;
        bus.redir_kind     = REDIR_JMP;
        bus.redir_target   = 32'd0;
        bus.redir_ret_addr = 32'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        no_redir();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_ovf", {31'd0, ras_overflow}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("boot_valid", {31'd0, bus.out_valid}, 32'd0);
        check("boot_addr", bus.imem_addr, 32'd0);
        step();
        check("f0_valid", {31'd0, bus.out_valid}, 32'd1);
        check("f0_pc", bus.out_pc, 32'd0);
        check("f0_instr", bus.out_instr, 32'd100);
        step();
        check("f1_pc", bus.out_pc, 32'd1);
        check("f1_instr", bus.out_instr, 32'd101);
        step();
        check("f2_pc", bus.out_pc, 32'd2);
        check("f2_instr", bus.out_instr, 32'd102);

        // Back-pressure while out_pc=2
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_pc", bus.out_pc, 32'd2);
            check("bp_instr", bus.out_instr, 32'd102);
            check("bp_addr", bus.imem_addr, 32'd3);
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        check("rel_pc", bus.out_pc, 32'd3);
        check("rel_instr", bus.out_instr, 32'd103);
        step();
        step();
        check("f5_pc", bus.out_pc, 32'd5);

        // JMP to 40
        redir(REDIR_JMP, 32'd40, 32'd0);
        step();
        no_redir();
        check("jmp_bubble", {31'd0, bus.out_valid}, 32'd0);
        check("jmp_addr", bus.imem_addr, 32'd40);
        step();
        check("jmp_pc", bus.out_pc, 32'd40);
        check("jmp_instr", bus.out_instr, 32'd140);
        check("jmp_valid", {31'd0, bus.out_valid}, 32'd1);

        // CALL then RET
        redir(REDIR_CALL, 32'h20, 32'd9);
        step();
        no_redir();
        check("call_addr", bus.imem_addr, 32'h20);
        check("call_bubble", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("call_pc", bus.out_pc, 32'h20);
        redir(REDIR_RET, 32'd777, 32'd0);
        step();
        no_redir();
        check("ret_addr", bus.imem_addr, 32'd9);
        check("ret_fault", {31'd0, fault}, 32'd0);
        step();
        check("ret_pc", bus.out_pc, 32'd9);
        check("ret_instr", bus.out_instr, 32'd109);

        // Reserved kind behaves as plain fetch
        redir(REDIR_RSVD, 32'd500, 32'd0);
        step();
        no_redir();
        check("rsvd_pc", bus.out_pc, 32'd10);
        check("rsvd_valid", {31'd0, bus.out_valid}, 32'd1);

        // Nine CALLs overflow the eight-entry stack
        for (int i = 1; i <= 9; i++) begin
            redir(REDIR_CALL, 32'h100 + 32'(i), 32'(i));
            step();
        end
        check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        check("ovf_addr", bus.imem_addr, 32'h109);
        for (int k = 0; k < 8; k++) begin
            redir(REDIR_RET, 32'd0, 32'd0);
            step();
            check("ras_pop", bus.imem_addr, 32'(9 - k));
        end
        no_redir();
        check("ras_fault", {31'd0, fault}, 32'd0);
        step();
        check("ras_last_pc", bus.out_pc, 32'd2);

        // PC wrap at 1023
        redir(REDIR_JMP, 32'd1023, 32'd0);
        step();
        no_redir();
        check("wrap_addr", bus.imem_addr, 32'd1023);
        step();
        check("wrap_pc_hi", bus.out_pc, 32'd1023);
        check("wrap_instr", bus.out_instr, 32'd1123);
        check("wrap_addr0", bus.imem_addr, 32'd0);
        step();
        check("wrap_pc_lo", bus.out_pc, 32'd0);
        check("wrap_instr0", bus.out_instr, 32'd100);

        // RET on empty stack
        redir(REDIR_RET, 32'd0, 32'd0);
        step();
        no_redir();
        check("ef_fault", {31'd0, fault}, 32'd1);
        check("ef_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ef_addr", bus.imem_addr, 32'd1);
        step();
        check("ef_fault2", {31'd0, fault}, 32'd1);
        check("ef_valid2", {31'd0, bus.out_valid}, 32'd0);
        redir(REDIR_JMP, 32'd50, 32'd0);
        step();
        no_redir();
        check("ef_jmp_addr", bus.imem_addr, 32'd1);
        check("ef_jmp_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ef_jmp_fault", {31'd0, fault}, 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_fault", {31'd0, fault}, 32'd0);
        check("ar_addr", bus.imem_addr, 32'd0);
        check("ar_ovf", {31'd0, ras_overflow}, 32'd0);
        check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_boot_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("ar_first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ar_first_pc", bus.out_pc, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
